// File: rtl/rv32i_types.sv
// Types shared by the RV32I memory-side blocks.
package rv32i_types;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_IMEM = 2'd1,
        ARB_DMEM = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates CPU fetch (imem) and load/store (dmem) ports onto one unified
// memory port; one transaction in flight, dmem-first with imem starvation relief.
//
// state    | meaning
// ARB_IDLE | no transaction outstanding; grant decided on the next edge
// ARB_IMEM | fetch issued on mem_*; waiting for mem_resp
// ARB_DMEM | load/store issued on mem_*; waiting for mem_resp
module mem_port_arbiter
    import rv32i_types::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] imem_addr,
    input  logic [3:0]  imem_rmask,
    output logic [31:0] imem_rdata,
    output logic        imem_resp,
    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_rmask,
    input  logic [3:0]  dmem_wmask,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_resp,
    input  logic        amo,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_rmask,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    arb_state_t    state_q, state_d;
    logic [CW-1:0] starve_cnt_q, starve_cnt_d;
    logic          amo_hold_q, amo_hold_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic [3:0]    mem_rmask_q, mem_rmask_d;
    logic [3:0]    mem_wmask_q, mem_wmask_d;

    logic imem_req, dmem_req, grant_imem, grant_dmem;

    always_comb begin
        imem_req   = |imem_rmask;
        dmem_req   = (|dmem_rmask) | (|dmem_wmask);
        grant_imem = 1'b0;
        grant_dmem = 1'b0;
        if (state_q == ARB_IDLE) begin
            // An open atomic pair locks imem out even when dmem is momentarily idle.
            if (amo_hold_q) begin
                grant_dmem = dmem_req;
            end else if (imem_req && dmem_req && (starve_cnt_q == CW'(STARVE_LIMIT))) begin
                grant_imem = 1'b1;
            end else if (dmem_req) begin
                grant_dmem = 1'b1;
            end else if (imem_req) begin
                grant_imem = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_rmask_d  = mem_rmask_q;
        mem_wmask_d  = mem_wmask_q;
        starve_cnt_d = starve_cnt_q;
        amo_hold_d   = amo_hold_q;
        imem_resp    = 1'b0;
        dmem_resp    = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (grant_imem) begin
                    state_d     = ARB_IMEM;
                    mem_addr_d  = imem_addr;
                    mem_rmask_d = imem_rmask;
                    mem_wmask_d = 4'h0;
                    mem_wdata_d = 32'h0;
                end else if (grant_dmem) begin
                    state_d     = ARB_DMEM;
                    mem_addr_d  = dmem_addr;
                    mem_rmask_d = dmem_rmask;
                    mem_wmask_d = dmem_wmask;
                    mem_wdata_d = dmem_wdata;
                end
            end
            ARB_IMEM: begin
                if (mem_resp) begin
                    imem_resp   = 1'b1;
                    state_d     = ARB_IDLE;
                    mem_rmask_d = 4'h0;
                    mem_wmask_d = 4'h0;
                end
            end
            ARB_DMEM: begin
                if (mem_resp) begin
                    dmem_resp   = 1'b1;
                    state_d     = ARB_IDLE;
                    mem_rmask_d = 4'h0;
                    mem_wmask_d = 4'h0;
                end
            end
            default: begin
                state_d     = ARB_IDLE;
                mem_rmask_d = 4'h0;
                mem_wmask_d = 4'h0;
            end
        endcase

        if (grant_imem) begin
            starve_cnt_d = '0;
        end else if (grant_dmem && imem_req && (starve_cnt_q != CW'(STARVE_LIMIT))) begin
            starve_cnt_d = starve_cnt_q + CW'(1);
        end

        if (grant_dmem && (|dmem_wmask)) begin
            amo_hold_d = 1'b0;
        end else if (grant_dmem && (|dmem_rmask) && amo) begin
            amo_hold_d = 1'b1;
        end else if ((state_q == ARB_IDLE) && !amo) begin
            amo_hold_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            mem_addr_q   <= 32'h0;
            mem_wdata_q  <= 32'h0;
            mem_rmask_q  <= 4'h0;
            mem_wmask_q  <= 4'h0;
            starve_cnt_q <= '0;
            amo_hold_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_rmask_q  <= mem_rmask_d;
            mem_wmask_q  <= mem_wmask_d;
            starve_cnt_q <= starve_cnt_d;
            amo_hold_q   <= amo_hold_d;
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_rmask  = mem_rmask_q;
    assign mem_wmask  = mem_wmask_q;
    assign imem_rdata = mem_rdata;
    assign dmem_rdata = mem_rdata;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, which sets the number of consecutive dmem grants allowed while imem waits.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port imem_addr  input  32  CPU fetch address.
REQ-005 SHALL have port imem_rmask  input  4  CPU fetch byte mask; nonzero means fetch pending.
REQ-006 SHALL have port imem_rdata  output  32  fetch data.
REQ-007 SHALL have port imem_resp  output  1  fetch-complete pulse.
REQ-008 SHALL have port dmem_addr  input  32  CPU load/store address.
REQ-009 SHALL have port dmem_rmask  input  4  load byte mask.
REQ-010 SHALL have port dmem_wmask  input  4  store byte mask.
REQ-011 SHALL have port dmem_wdata  input  32  store data.
REQ-012 SHALL have port dmem_rdata  output  32  load data.
REQ-013 SHALL have port dmem_resp  output  1  load/store-complete pulse.
REQ-014 SHALL have port amo  input  1  marks the current dmem access as part of an atomic read-then-write pair.
REQ-015 SHALL have port mem_addr  output  32  unified memory address.
REQ-016 SHALL have port mem_rmask  output  4  unified read mask.
REQ-017 SHALL have port mem_wmask  output  4  unified write mask.
REQ-018 SHALL have port mem_wdata  output  32  unified write data.
REQ-019 SHALL have port mem_rdata  input  32  unified read data.
REQ-020 SHALL have port mem_resp  input  1  unified completion pulse.

Function
REQ-021 SHALL implement FSM states ARB_IDLE, ARB_IMEM, ARB_DMEM; only one memory transaction outstanding.
REQ-022 Pending definition SHALL be: imem_req = |imem_rmask; dmem_req = |dmem_rmask or |dmem_wmask.
REQ-023 In ARB_IDLE, on the clock edge with any request, the block SHALL grant one requester, register its addr/masks/wdata into mem_* outputs, and move to ARB_IMEM or ARB_DMEM; for imem, mem_wmask = 0 and mem_wdata = 0.
REQ-024 Grant priority SHALL be: amo_hold set → dmem only (imem waits even if dmem idle); else both pending and starve_cnt == STARVE_LIMIT → imem; else dmem over imem.
REQ-025 starve_cnt SHALL increment on a dmem grant made while imem_req is high (saturating at STARVE_LIMIT), and clear on any imem grant.
REQ-026 mem_* outputs SHALL stay constant while in ARB_IMEM/ARB_DMEM until mem_resp; CPU inputs changing mid-transaction SHALL be ignored.
REQ-027 In a busy state with mem_resp high, the block SHALL assert imem_resp or dmem_resp (per state) combinationally that cycle, return to ARB_IDLE at the edge, and drive mem_rmask = mem_wmask = 0 the next cycle.
REQ-028 imem_rdata and dmem_rdata SHALL both equal mem_rdata at all times; only the resp pulse qualifies them.
REQ-029 Minimum latency SHALL be: request visible cycle N → mem_* valid cycle N+1 → earliest CPU resp cycle N+1 if mem_resp is same-cycle.
REQ-030 A request still asserted in the resp cycle SHALL NOT be regranted in that cycle; it is re-evaluated in ARB_IDLE the next cycle.
REQ-031 amo_hold SHALL set on a dmem read grant with amo = 1, and clear on the next dmem write grant or on any cycle in ARB_IDLE with amo = 0.
REQ-032 mem_resp in ARB_IDLE SHALL be ignored; no resp is generated.

Reset
REQ-033 On rst, asynchronously: state = ARB_IDLE, mem_addr/mem_wdata = 0, mem_rmask/mem_wmask = 0, starve_cnt = 0, amo_hold = 0, imem_resp = dmem_resp = 0; an in-flight transaction is abandoned.

Structure
REQ-034 arb_state_t SHALL live in shared package rv32i_types.
REQ-035 The block SHALL be a single module with no sub-modules; the starvation counter and amo_hold are internal registers.

Verification
REQ-036 Imem only: imem_rmask=F, addr=0x60000000, mem_resp after 3 cycles with rdata=0x00000013 → single imem_resp with imem_rdata=0x13; mem_wmask=0 throughout.
REQ-037 Simultaneous imem and dmem store (addr 0x100, wmask=F, wdata=0xDEADBEEF) → dmem granted first with mem_wdata=0xDEADBEEF; imem granted in the cycle after dmem_resp.
REQ-038 Starvation: imem held pending while dmem issues 6 back-to-back loads → grant order D,D,D,D,I,D,D.
REQ-039 AMO: amo=1, dmem load then store to 0x200 with imem pending throughout → no imem grant between the read resp and the write grant.
REQ-040 Reset: rst asserted 1 cycle into ARB_DMEM → mem masks 0 immediately, no dmem_resp, and a later mem_resp is ignored.
